// File: rtl/timer_arbiter.sv
// Shared delay timer arbitrated among N_REQ requesters; winner waits its delay then gets a done pulse.
// Optional round-robin arbitration with TIMER_ARB_RR_EN, otherwise fixed priority (lowest index wins).
module timer_arbiter #(
  parameter int N_REQ = 4,
  parameter int CW    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*CW-1:0]   delay,
  output logic [N_REQ-1:0]      grant,
  output logic [N_REQ-1:0]      done,
  output logic                  busy,
  output logic [CW-1:0]         count
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    win_q;
  logic [CW-1:0]    cnt_q;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] done_q;
  logic             busy_q;

  logic             arb_vld;
  logic [IW-1:0]    arb_idx;
  logic [CW-1:0]    slice;
  logic             owner_req;

  always_comb begin
    slice     = delay[int'(win_q)*CW +: CW];
    owner_req = req[win_q];
  end

`ifdef TIMER_ARB_RR_EN
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  int            idx;

  // Walk from the farthest candidate back to the pointer so the closest one wins.
  always_comb begin
    arb_vld = 1'b0;
    arb_idx = '0;
    idx     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[IW'(idx)]) begin
        arb_vld = 1'b1;
        arb_idx = IW'(idx);
      end
    end
    ptr_d = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + IW'(1);
  end
`else
  always_comb begin
    arb_vld = 1'b0;
    arb_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[IW'(i)]) begin
        arb_vld = 1'b1;
        arb_idx = IW'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
`ifdef TIMER_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (arb_vld) begin
            state_q <= LOAD;
            win_q   <= arb_idx;
            grant_q <= N_REQ'(1) << arb_idx;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
`ifdef TIMER_ARB_RR_EN
          ptr_q <= ptr_d;
`endif
          if (!owner_req) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end else if (slice == '0) begin
            state_q <= DONE;
            cnt_q   <= '0;
            done_q  <= grant_q;
          end else begin
            state_q <= RUN;
            cnt_q   <= slice;
          end
        end
        RUN: begin
          // Abort outranks expiry: a dropped request never sees done.
          if (!owner_req) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            cnt_q   <= '0;
            done_q  <= grant_q;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = cnt_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: expected jobs are queued when driven and checked at each done pulse.
module tb_timer_arbiter;

  localparam int N  = 4;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*CW-1:0] delay;
  logic [N-1:0]  grant;
  logic [N-1:0]  done;
  logic          busy;
  logic [CW-1:0] count;

  typedef struct {
    int idx;
    int lat;
  } job_t;

  job_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cmax   = 0;

  timer_arbiter #(.N_REQ(N), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .delay (delay),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps until a done pulse (cycle numbers continue from k0), then pops and checks the scoreboard.
  task automatic expect_done(input string tag, input int k0, input int chg_step, input int limit);
    int          k;
    job_t        e;
    logic [N-1:0] d;
    logic [N-1:0] g;
    logic [N-1:0] one;
    k = -1;
    d = '0;
    g = '0;
    for (int s = k0 + 1; s <= limit; s++) begin
      step();
      if (s == chg_step) delay = {N{8'd1}};
      if (int'(count) > cmax) cmax = int'(count);
      if (done != '0) begin
        k = s;
        d = done;
        g = grant;
        break;
      end
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e   = sb.pop_front();
      one = 4'b0001 << e.idx;
      chk({tag, "_lat"},   k,  e.lat);
      chk({tag, "_done"},  32'(d), 32'(one));
      chk({tag, "_grant"}, 32'(g), 32'(one));
    end
  endtask

  initial begin
    logic [N-1:0] acc;
    int           found;

    rst   = 1'b1;
    req   = '0;
    delay = '0;
    step();
    step();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rst = 1'b0;
    step();

    // Single job, delay 5: grant from T+1, done at T+7, idle at T+8.
    delay[0*CW +: CW] = 8'd5;
    req = 4'b0001;
    sb.push_back('{idx: 0, lat: 7});
    step();
    chk("t1_grant_t1", 32'(grant), 32'b0001);
    chk("t1_busy_t1",  32'(busy),  32'd1);
    expect_done("t1", 1, -1, 40);
    req = '0;
    step();
    chk("t1_busy_t8", 32'(busy), 32'd0);
    chk("t1_done_t8", 32'(done), 32'd0);

    // Zero delay: LOAD then DONE straight away, counter never leaves 0.
    delay[1*CW +: CW] = 8'd0;
    req  = 4'b0010;
    cmax = 0;
    sb.push_back('{idx: 1, lat: 2});
    expect_done("t2", 0, -1, 20);
    req = '0;
    chk("t2_cmax", cmax, 0);
    step();

    // Abort while count is 3.
    delay[0*CW +: CW] = 8'd10;
    req   = 4'b0001;
    found = 0;
    for (int s = 0; s < 30; s++) begin
      step();
      if (count == 8'd3) begin
        found = 1;
        break;
      end
    end
    chk("t3_reach3", found, 1);
    req = '0;
    step();
    chk("t3_grant", 32'(grant), 32'd0);
    chk("t3_busy",  32'(busy),  32'd0);
    chk("t3_count", 32'(count), 32'd0);
    acc = '0;
    for (int s = 0; s < 4; s++) begin
      acc = acc | done;
      step();
    end
    chk("t3_nodone", 32'(acc), 32'd0);

    // Fresh pointer, all requesting with delay 1: back-to-back jobs.
    rst = 1'b1;
    step();
    rst   = 1'b0;
    delay = {N{8'd1}};
    req   = 4'b1111;
    for (int j = 0; j < 5; j++) begin
`ifdef TIMER_ARB_RR_EN
      sb.push_back('{idx: j % N, lat: (j == 0) ? 3 : 4});
`else
      sb.push_back('{idx: 0, lat: (j == 0) ? 3 : 4});
`endif
    end
    for (int j = 0; j < 5; j++) begin
      expect_done($sformatf("t4_j%0d", j), 0, -1, 20);
    end
    req = '0;
    step();
    step();

    // Reset mid-run at count 100, then a new request is served.
    delay[0*CW +: CW] = 8'd120;
    req   = 4'b0001;
    found = 0;
    for (int s = 0; s < 200; s++) begin
      step();
      if (count == 8'd100) begin
        found = 1;
        break;
      end
    end
    chk("t5_reach100", found, 1);
    rst = 1'b1;
    step();
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_done",  32'(done),  32'd0);
    chk("t5_busy",  32'(busy),  32'd0);
    chk("t5_count", 32'(count), 32'd0);
    rst = 1'b0;
    delay[2*CW +: CW] = 8'd3;
    req = 4'b0100;
    sb.push_back('{idx: 2, lat: 5});
    expect_done("t5_after", 0, -1, 30);
    req = '0;
    step();

    // Max delay; delay input rewritten after LOAD must be ignored.
    delay = '0;
    delay[0*CW +: CW] = 8'd255;
    req  = 4'b0001;
    cmax = 0;
    sb.push_back('{idx: 0, lat: 257});
    expect_done("t6", 0, 2, 400);
    req = '0;
    chk("t6_cmax", cmax, 255);
    step();
    chk("t6_idle_busy", 32'(busy), 32'd0);

    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
